// File: rtl/hit_win_pkg.sv
// Shared definitions for the hit/lock window sequencer: default widths
// and the 3-bit state codes reported on stu_state.
package hit_win_pkg;

  localparam int DW_DEF = 16;
  localparam int CW_DEF = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_HIT   = 3'd2;
  localparam logic [2:0] ST_LOCK  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ARMED = ST_ARMED,
    S_HIT   = ST_HIT,
    S_LOCK  = ST_LOCK,
    S_HOLD  = ST_HOLD
  } state_e;

endpackage

// File: rtl/hit_win_trig.sv
// Rising threshold-crossing detector. Keeps the last qualified sample and
// flags a sample that reaches th while the previous one was below th.
// set_ones forces the previous sample to all-ones so a level that is already
// above threshold cannot fire; a fresh low-then-high crossing is needed.
module hit_win_trig #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          set_ones,
  input  logic          sm_vld,
  input  logic [DW-1:0] sm_data,
  input  logic [DW-1:0] th,
  output logic          trig
);

  logic [DW-1:0] prev_q;

  // previous-sample register; only qualified samples are remembered
  always_ff @(posedge clk) begin
    if (clr) begin
      prev_q <= '0;
    end else if (set_ones) begin
      prev_q <= '1;
    end else if (sm_vld) begin
      prev_q <= sm_data;
    end
  end

  assign trig = sm_vld & (sm_data >= th) & (prev_q < th);

endmodule

// File: rtl/hit_win_ctrl.sv
// Hit/lock window sequencer. Arms on cmd_arm, waits for a rising threshold
// crossing on sm_data, then plays HIT -> LOCK -> HOLD using one shared
// down-counter loaded from config latched at the trigger.
// Optional feature macro: HIT_WIN_AUTO_REARM_EN (end of sequence returns to
// ARMED with the previous sample forced to all-ones instead of going IDLE).
//
// Interface qualifiers: sm_vld marks a sample as valid in the cycle it is
// high and ph_vld is a one-cycle event; neither has a ready/backpressure
// path, every qualified cycle is consumed.
module hit_win_ctrl
  import hit_win_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic [DW-1:0] sm_data,
  input  logic          sm_vld,
  input  logic [DW-1:0] cfg_trig_th,
  input  logic [CW-1:0] cfg_hit_len,
  input  logic [CW-1:0] cfg_lock_len,
  input  logic [CW-1:0] cfg_holdoff,
  input  logic          cmd_arm,
  input  logic          cmd_abort,
  input  logic          ph_vld,
  output logic          stu_now_hit,
  output logic          stu_now_lock,
  output logic [2:0]    stu_state,
  output logic [15:0]   stu_win_cnt,
  output logic          busy
);

`ifdef HIT_WIN_AUTO_REARM_EN
  localparam bit AUTO_REARM = 1'b1;
`else
  localparam bit AUTO_REARM = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] lock_len_q, lock_len_d;
  logic [CW-1:0] holdoff_q, holdoff_d;
  logic          hit_q, lock_q, busy_q;
  logic [15:0]   win_cnt_q;
  logic          trig;
  logic          set_ones;
  logic          end_seq;
  logic [CW-1:0] hit_len_eff;

  // a zero hit length still yields one hit cycle
  assign hit_len_eff = (cfg_hit_len == '0) ? CW'(1) : cfg_hit_len;

  hit_win_trig #(.DW(DW)) u_trig (
    .clk      (clk_sys),
    .clr      (rst),
    .set_ones (set_ones),
    .sm_vld   (sm_vld),
    .sm_data  (sm_data),
    .th       (cfg_trig_th),
    .trig     (trig)
  );

  // next-state, counter reload and latched-config selection
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lock_len_d = lock_len_q;
    holdoff_d  = holdoff_q;
    end_seq    = 1'b0;
    set_ones   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_arm) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (trig) begin
          state_d    = S_HIT;
          cnt_d      = hit_len_eff;
          lock_len_d = cfg_lock_len;
          holdoff_d  = cfg_holdoff;
        end
      end
      S_HIT: begin
        if (cnt_q <= CW'(1)) begin
          if (lock_len_q != '0) begin
            state_d = S_LOCK;
            cnt_d   = lock_len_q;
          end else if (holdoff_q != '0) begin
            state_d = S_HOLD;
            cnt_d   = holdoff_q;
          end else begin
            end_seq = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_LOCK: begin
        if (cnt_q <= CW'(1)) begin
          if (holdoff_q != '0) begin
            state_d = S_HOLD;
            cnt_d   = holdoff_q;
          end else begin
            end_seq = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q <= CW'(1)) begin
          end_seq = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (end_seq) begin
      state_d  = AUTO_REARM ? S_ARMED : S_IDLE;
      set_ones = AUTO_REARM;
    end

    // abort overrides arm, trigger and end-of-sequence
    if (cmd_abort) begin
      state_d  = S_IDLE;
      set_ones = 1'b0;
    end
  end

  // state, counter, latched config and registered window outputs
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lock_len_q <= '0;
      holdoff_q  <= '0;
      hit_q      <= 1'b0;
      lock_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lock_len_q <= lock_len_d;
      holdoff_q  <= holdoff_d;
      hit_q      <= (state_d == S_HIT);
      lock_q     <= (state_d == S_LOCK);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  // free-running count of result-valid pulses, independent of state
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      win_cnt_q <= '0;
    end else if (ph_vld) begin
      win_cnt_q <= win_cnt_q + 16'd1;
    end
  end

  assign stu_now_hit  = hit_q;
  assign stu_now_lock = lock_q;
  assign stu_state    = state_q;
  assign stu_win_cnt  = win_cnt_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_hit_win_ctrl.sv
// Bench for hit_win_ctrl. A phase-list reference model predicts the packed
// outputs {state, hit, lock, busy, win_cnt} for every cycle; scenario tasks
// compare against it and against fixed window lengths.
module tb_hit_win_ctrl;
  import hit_win_pkg::*;

  localparam int DW = 16;
  localparam int CW = 16;

`ifdef HIT_WIN_AUTO_REARM_EN
  localparam bit REARM = 1'b1;
`else
  localparam bit REARM = 1'b0;
`endif

  // clock / reset
  logic          clk_sys = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] sm_data = '0;
  logic          sm_vld = 1'b0;
  logic [DW-1:0] cfg_trig_th = 16'd100;
  logic [CW-1:0] cfg_hit_len = '0;
  logic [CW-1:0] cfg_lock_len = '0;
  logic [CW-1:0] cfg_holdoff = '0;
  logic          cmd_arm = 1'b0;
  logic          cmd_abort = 1'b0;
  logic          ph_vld = 1'b0;
  logic          stu_now_hit, stu_now_lock, busy;
  logic [2:0]    stu_state;
  logic [15:0]   stu_win_cnt;

  always #5 clk_sys = ~clk_sys;

  hit_win_ctrl #(.DW(DW), .CW(CW)) dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .sm_data      (sm_data),
    .sm_vld       (sm_vld),
    .cfg_trig_th  (cfg_trig_th),
    .cfg_hit_len  (cfg_hit_len),
    .cfg_lock_len (cfg_lock_len),
    .cfg_holdoff  (cfg_holdoff),
    .cmd_arm      (cmd_arm),
    .cmd_abort    (cmd_abort),
    .ph_vld       (ph_vld),
    .stu_now_hit  (stu_now_hit),
    .stu_now_lock (stu_now_lock),
    .stu_state    (stu_state),
    .stu_win_cnt  (stu_win_cnt),
    .busy         (busy)
  );

  int total = 0;
  int bad   = 0;

  // scoreboard
  logic [21:0] exp_q[$];

  // reference model: current phase code plus the list of phases still to play
  int            m_st = 0;
  int            plan[$];
  logic [DW-1:0] m_prev = '0;
  logic [15:0]   m_cnt = '0;

  function automatic logic [21:0] observed();
    return {stu_state, stu_now_hit, stu_now_lock, busy, stu_win_cnt};
  endfunction

  task automatic model_reset();
    m_st = 0;
    plan.delete();
    m_prev = '0;
    m_cnt = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic arm, input logic abort, input logic vld,
                            input logic [DW-1:0] data, input logic ph);
    bit trig;
    bit ended;
    int h;
    trig  = (m_st == 1) && vld && (data >= cfg_trig_th) && (m_prev < cfg_trig_th);
    ended = 0;
    if (abort) begin
      m_st = 0;
      plan.delete();
    end else if (m_st == 0) begin
      if (arm) m_st = 1;
    end else if (m_st == 1) begin
      if (trig) begin
        h = (cfg_hit_len == 0) ? 1 : int'(cfg_hit_len);
        for (int i = 0; i < h; i++) plan.push_back(2);
        for (int i = 0; i < int'(cfg_lock_len); i++) plan.push_back(3);
        for (int i = 0; i < int'(cfg_holdoff); i++) plan.push_back(4);
        m_st = plan.pop_front();
      end
    end else begin
      if (plan.size() == 0) begin
        ended = 1;
        m_st = REARM ? 1 : 0;
      end else begin
        m_st = plan.pop_front();
      end
    end
    if (ended && REARM) m_prev = '1;
    else if (vld) m_prev = data;
    if (ph) m_cnt = m_cnt + 16'd1;
    exp_q.push_back({3'(m_st), 1'(m_st == 2), 1'(m_st == 3), 1'(m_st != 0), m_cnt});
  endtask

  // driver: one clock cycle of stimulus; returns DUT and model outputs after the edge
  task automatic step(input logic arm, input logic abort, input logic vld,
                      input logic [DW-1:0] data, input logic ph,
                      output logic [21:0] got, output logic [21:0] exp);
    @(negedge clk_sys);
    cmd_arm = arm;
    cmd_abort = abort;
    sm_vld = vld;
    sm_data = data;
    ph_vld = ph;
    @(posedge clk_sys);
    model_step(arm, abort, vld, data, ph);
    #1;
    got = observed();
    exp = exp_q.pop_front();
  endtask

  task automatic test_reset();
    logic [21:0] got;
    @(negedge clk_sys);
    rst = 1'b1;
    cmd_arm = 1'b1;
    ph_vld = 1'b1;
    sm_vld = 1'b1;
    sm_data = 16'd500;
    repeat (2) @(posedge clk_sys);
    #1;
    got = observed();
    total++;
    if (got !== 22'd0) begin
      $display("FAIL reset_state got=%h exp=%h", got, 22'd0);
      bad++;
    end
    model_reset();
    @(negedge clk_sys);
    rst = 1'b0;
    cmd_arm = 1'b0;
    ph_vld = 1'b0;
    sm_vld = 1'b0;
    sm_data = '0;
  endtask

  task automatic test_basic();
    logic [21:0] got, exp;
    int hit_n = 0, lock_n = 0;
    cfg_hit_len = 16'd8; cfg_lock_len = 16'd4; cfg_holdoff = 16'd0;
    step(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, got, exp);
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, got, exp);
    step(1'b0, 1'b0, 1'b1, 16'd50, 1'b0, got, exp);
    step(1'b0, 1'b0, 1'b1, 16'd150, 1'b0, got, exp);
    total++;
    if (stu_now_hit !== 1'b1) begin
      $display("FAIL basic_first_hit got=%b exp=1", stu_now_hit);
      bad++;
    end
    hit_n = int'(stu_now_hit);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 99)),
           1'($urandom_range(0, 1)), got, exp);
      total++;
      if (got !== exp) begin
        $display("FAIL basic_cycle%0d got=%h exp=%h", i, got, exp);
        bad++;
      end
      hit_n += int'(stu_now_hit);
      lock_n += int'(stu_now_lock);
      if (stu_now_hit && stu_now_lock) lock_n += 100;
    end
    total++;
    if (hit_n != 8 || lock_n != 4) begin
      $display("FAIL basic_lengths got=hit%0d/lock%0d exp=hit8/lock4", hit_n, lock_n);
      bad++;
    end
    total++;
    if (busy !== 1'b0 || stu_state !== ST_IDLE) begin
      $display("FAIL basic_end got=busy%b/st%0d exp=busy0/st0", busy, stu_state);
      bad++;
    end
  endtask

  task automatic test_min_window();
    logic [21:0] got, exp;
    int hit_n = 0;
    cfg_hit_len = 16'd0; cfg_lock_len = 16'd0; cfg_holdoff = 16'd0;
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, got, exp);
    step(1'b0, 1'b0, 1'b1, 16'd50, 1'b0, got, exp);
    for (int i = 0; i < 8; i++) begin
      logic [DW-1:0] d;
      d = (i % 2 == 0) ? 16'd150 : 16'd50;
      step(1'b0, 1'b0, 1'b1, d, 1'b0, got, exp);
      total++;
      if (got !== exp) begin
        $display("FAIL min_cycle%0d got=%h exp=%h", i, got, exp);
        bad++;
      end
      hit_n += int'(stu_now_hit);
    end
    total++;
    if (hit_n != 1 || stu_state !== ST_IDLE) begin
      $display("FAIL min_window got=hit%0d/st%0d exp=hit1/st0", hit_n, stu_state);
      bad++;
    end
  endtask

  task automatic test_abort();
    logic [21:0] got, exp;
    cfg_hit_len = 16'd8; cfg_lock_len = 16'd3; cfg_holdoff = 16'd2;
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, got, exp);
    step(1'b0, 1'b0, 1'b1, 16'd50, 1'b0, got, exp);
    step(1'b0, 1'b0, 1'b1, 16'd150, 1'b1, got, exp);
    step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, got, exp);
    step(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, got, exp);
    total++;
    if (stu_now_hit !== 1'b1) begin
      $display("FAIL abort_in_hit3 got=%b exp=1", stu_now_hit);
      bad++;
    end
    step(1'b1, 1'b1, 1'b0, 16'd0, 1'b0, got, exp);
    total++;
    if (got !== exp || stu_now_hit !== 1'b0 || stu_state !== ST_IDLE) begin
      $display("FAIL abort_hit got=%h exp=%h", got, exp);
      bad++;
    end
    step(1'b1, 1'b1, 1'b0, 16'd0, 1'b0, got, exp);
    total++;
    if (stu_state !== ST_IDLE || got !== exp) begin
      $display("FAIL arm_abort_idle got=%h exp=%h", got, exp);
      bad++;
    end
    // reset in the middle of a window clears everything, including win_cnt
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, got, exp);
    step(1'b0, 1'b0, 1'b1, 16'd10, 1'b0, got, exp);
    step(1'b0, 1'b0, 1'b1, 16'd200, 1'b1, got, exp);
    total++;
    if (got !== exp) begin
      $display("FAIL pre_reset_window got=%h exp=%h", got, exp);
      bad++;
    end
    test_reset();
  endtask

  task automatic test_cfg_change();
    logic [21:0] got, exp;
    int hit_n;
    cfg_hit_len = 16'd8; cfg_lock_len = 16'd0; cfg_holdoff = 16'd0;
    for (int w = 0; w < 2; w++) begin
      hit_n = 0;
      step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, got, exp);
      step(1'b0, 1'b0, 1'b1, 16'd50, 1'b0, got, exp);
      step(1'b0, 1'b0, 1'b1, 16'd150, 1'b0, got, exp);
      hit_n += int'(stu_now_hit);
      cfg_hit_len = 16'd2;
      for (int i = 0; i < 10; i++) begin
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'($urandom_range(0, 1)), got, exp);
        total++;
        if (got !== exp) begin
          $display("FAIL cfgchg_w%0d_cycle%0d got=%h exp=%h", w, i, got, exp);
          bad++;
        end
        hit_n += int'(stu_now_hit);
      end
      total++;
      if (hit_n != ((w == 0) ? 8 : 2)) begin
        $display("FAIL cfgchg_len_w%0d got=%0d exp=%0d", w, hit_n, (w == 0) ? 8 : 2);
        bad++;
      end
    end
  endtask

  task automatic test_vld_and_hold();
    logic [21:0] got, exp;
    int hold_n = 0, hit_n = 0;
    cfg_hit_len = 16'd2; cfg_lock_len = 16'd0; cfg_holdoff = 16'd10;
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, got, exp);
    step(1'b0, 1'b0, 1'b1, 16'd50, 1'b0, got, exp);
    step(1'b0, 1'b0, 1'b0, 16'd150, 1'b0, got, exp);
    total++;
    if (stu_state !== ST_ARMED || got !== exp) begin
      $display("FAIL novld_trigger got=st%0d exp=st1", stu_state);
      bad++;
    end
    step(1'b0, 1'b0, 1'b1, 16'd150, 1'b0, got, exp);
    hit_n += int'(stu_now_hit);
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] d;
      d = (i % 2 == 0) ? 16'd50 : 16'd150;
      step(1'b0, 1'b0, 1'b1, d, 1'b0, got, exp);
      total++;
      if (got !== exp) begin
        $display("FAIL hold_cycle%0d got=%h exp=%h", i, got, exp);
        bad++;
      end
      hit_n += int'(stu_now_hit);
      if (stu_state === ST_HOLD) hold_n++;
      if (stu_state === ST_HOLD && (stu_now_hit || stu_now_lock || !busy)) hold_n += 100;
    end
    total++;
    if (hold_n != 10 || hit_n != 2 || stu_state !== ST_IDLE) begin
      $display("FAIL hold_len got=hold%0d/hit%0d exp=hold10/hit2", hold_n, hit_n);
      bad++;
    end
  endtask

  task automatic test_random();
    logic [21:0] got, exp;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        cfg_hit_len  = 16'($urandom_range(0, 5));
        cfg_lock_len = 16'($urandom_range(0, 5));
        cfg_holdoff  = 16'($urandom_range(0, 5));
      end
      step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 1)), 16'($urandom_range(0, 200)),
           1'($urandom_range(0, 3) == 0), got, exp);
      total++;
      if (got !== exp) begin
        $display("FAIL random_cycle%0d got=%h exp=%h", i, got, exp);
        bad++;
      end
    end
  endtask

`ifdef HIT_WIN_AUTO_REARM_EN
  task automatic test_rearm();
    logic [21:0] got, exp;
    int hit_n = 0;
    test_reset();
    cfg_hit_len = 16'd3; cfg_lock_len = 16'd2; cfg_holdoff = 16'd0;
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, got, exp);
    step(1'b0, 1'b0, 1'b1, 16'd50, 1'b0, got, exp);
    step(1'b0, 1'b0, 1'b1, 16'd150, 1'b1, got, exp);
    hit_n += int'(stu_now_hit);
    total++;
    if (stu_win_cnt !== 16'd2) begin
      $display("FAIL rearm_wincnt got=%0d exp=2", stu_win_cnt);
      bad++;
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 1'b1, 16'd150, 1'b0, got, exp);
      total++;
      if (got !== exp) begin
        $display("FAIL rearm_hold_cycle%0d got=%h exp=%h", i, got, exp);
        bad++;
      end
      hit_n += int'(stu_now_hit);
    end
    total++;
    if (hit_n != 3 || stu_state !== ST_ARMED) begin
      $display("FAIL rearm_no_retrig got=hit%0d/st%0d exp=hit3/st1", hit_n, stu_state);
      bad++;
    end
    step(1'b0, 1'b0, 1'b1, 16'd50, 1'b0, got, exp);
    step(1'b0, 1'b0, 1'b1, 16'd150, 1'b0, got, exp);
    total++;
    if (stu_now_hit !== 1'b1 || got !== exp) begin
      $display("FAIL rearm_second got=%h exp=%h", got, exp);
      bad++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_min_window();
    test_abort();
    test_cfg_change();
    test_vld_and_hold();
    test_random();
`ifdef HIT_WIN_AUTO_REARM_EN
    test_rearm();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
